// File: rtl/imem_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : imem_fetch
//  Description : Instruction fetch initiator. Owns the program counter, drives
//                the word address into a combinational-read instruction
//                memory, and captures each returned word in a one-entry fetch
//                register (IF/ID) with a valid flag. Supports decode stall,
//                branch/jump redirect with flush, and stop-on-halt-word.
//
//  Ports       : clk            system clock, rising-edge state updates
//                reset          synchronous active-high reset
//                start          level; begins fetching from PC while idle
//                imem_addr      word address to imem (the PC register)
//                imem_readdata  imem data, valid in the same cycle
//                stall          decode not ready; hold PC and fetch register
//                redirect       load redirect_addr into PC, flush fetch reg
//                redirect_addr  redirect target PC
//                instr          registered instruction word
//                instr_pc       PC that instr was fetched from
//                instr_valid    instr holds a live instruction
//                halted         high while stopped on a halt word
//
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch #(
    parameter int             N         = 16,
    parameter int             R         = 5,
    parameter logic [N-1:0]   HALT_WORD = 16'hFFFF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [R-1:0]  imem_addr,
    input  logic [N-1:0]  imem_readdata,
    input  logic          stall,
    input  logic          redirect,
    input  logic [R-1:0]  redirect_addr,
    output logic [N-1:0]  instr,
    output logic [R-1:0]  instr_pc,
    output logic          instr_valid,
    output logic          halted
);

    localparam logic [1:0]   c_ST_IDLE = 2'd0;
    localparam logic [1:0]   c_ST_RUN  = 2'd1;
    localparam logic [1:0]   c_ST_HALT = 2'd2;
    localparam logic [R-1:0] c_PC_ONE  = R'(1);

    logic [1:0]   r_state;
    logic [R-1:0] r_pc;
    logic [N-1:0] r_instr;
    logic [R-1:0] r_instr_pc;
    logic         r_instr_valid;

    logic [1:0]   w_next_state;
    logic [R-1:0] w_next_pc;
    logic [N-1:0] w_next_instr;
    logic [R-1:0] w_next_instr_pc;
    logic         w_next_instr_valid;
    logic         w_is_halt_word;

    assign w_is_halt_word = (imem_readdata == HALT_WORD);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_pc          <= '0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_pc          <= w_next_pc;
            r_instr       <= w_next_instr;
            r_instr_pc    <= w_next_instr_pc;
            r_instr_valid <= w_next_instr_valid;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state       = r_state;
        w_next_pc          = r_pc;
        w_next_instr       = r_instr;
        w_next_instr_pc    = r_instr_pc;
        w_next_instr_valid = r_instr_valid;

        case (r_state)
            c_ST_IDLE: begin
                w_next_instr_valid = 1'b0;
                // Redirect and start may coincide: PC takes the target and
                // fetching begins from it on the next cycle.
                if (redirect) begin
                    w_next_pc = redirect_addr;
                end
                if (start) begin
                    w_next_state = c_ST_RUN;
                end
            end

            c_ST_RUN: begin
                if (redirect) begin
                    // Flush: the word currently on imem_readdata is discarded,
                    // costing one bubble. instr_pc keeps its old value.
                    w_next_pc          = redirect_addr;
                    w_next_instr       = '0;
                    w_next_instr_valid = 1'b0;
                end else if (!stall) begin
                    w_next_instr       = imem_readdata;
                    w_next_instr_pc    = r_pc;
                    w_next_instr_valid = 1'b1;
                    if (w_is_halt_word) begin
                        // Halt word is delivered valid; PC parks on it.
                        w_next_state = c_ST_HALT;
                    end else begin
                        w_next_pc = r_pc + c_PC_ONE;
                    end
                end
            end

            c_ST_HALT: begin
                if (redirect) begin
                    w_next_pc          = redirect_addr;
                    w_next_instr_valid = 1'b0;
                    w_next_state       = c_ST_RUN;
                end else if (!stall) begin
                    // Decode has consumed the halt word.
                    w_next_instr_valid = 1'b0;
                end
            end

            default: begin
                w_next_state       = c_ST_IDLE;
                w_next_instr_valid = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        imem_addr   = r_pc;
        instr       = r_instr;
        instr_pc    = r_instr_pc;
        instr_valid = r_instr_valid;
        halted      = (r_state == c_ST_HALT);
    end

endmodule
`default_nettype wire

// File: doc/imem_fetch.md
Name: imem_fetch

Overview:
- Initiator side of the instruction memory read interface.
- Owns the program counter and drives the word address into imem. imem returns its read data combinationally in the same cycle.
- Registers each fetched word into a one-entry fetch register (the IF/ID stage) with a valid flag.
- Supports stall from decode, PC redirect for branches and jumps, and a halt-instruction stop.

Parameters:
- n, 16, instruction/data word width in bits.
- r, 5, imem address width; imem holds 2**r words, word-addressed.
- HALT_WORD, 16'hFFFF, instruction encoding that stops fetch.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begins fetching from the current PC when idle.
- imem_addr  output  r  word address to imem; equals the PC register, combinational from it.
- imem_readdata  input  n  imem read data; valid in the same cycle as imem_addr.
- stall  input  1  decode not ready; fetch register and PC are held.
- redirect  input  1  load a new PC and flush the fetch register.
- redirect_addr  input  r  target PC, used when redirect=1.
- instr  output  n  registered instruction word.
- instr_pc  output  r  PC the current instr was fetched from.
- instr_valid  output  1  instr holds a live instruction.
- halted  output  1  high while the FSM is in HALT.

Behaviour:
- Reset values (reset sampled high at a clk edge):
  - pc=0, state=IDLE
  - instr=0, instr_pc=0, instr_valid=0, halted=0
  - reset overrides every other input, including mid-run.
- FSM states: IDLE, RUN, HALT.
- IDLE:
  - instr_valid=0.
  - start=1 -> RUN next cycle; pc unchanged.
  - redirect=1 in IDLE loads pc=redirect_addr and stays in IDLE.
- RUN, one rising edge, priority redirect > stall > normal:
  - redirect=1: pc<=redirect_addr, instr<=0, instr_valid<=0, instr_pc unchanged. The flushed slot costs exactly one bubble.
  - else stall=1: pc, instr, instr_pc and instr_valid all hold.
  - else normal: instr<=imem_readdata, instr_pc<=pc, instr_valid<=1.
    - If imem_readdata != HALT_WORD: pc<=pc+1 mod 2**r.
    - If imem_readdata == HALT_WORD: pc holds, state<=HALT. The halt word itself is delivered valid.
- HALT:
  - halted=1; pc held.
  - stall=0: instr_valid<=0 (halt word consumed). stall=1: instr_valid holds.
  - redirect=1: pc<=redirect_addr, instr_valid<=0, state<=RUN. This is a restart.
  - start is ignored.
- Latency:
  - Address presented in cycle k; word is visible at instr after edge k+1.
  - Sustained throughput is 1 instruction per cycle with no stall.
- Width/wrap: pc is an r-bit unsigned register. PC 2**r-1 increments to 0 with no error flag.
- Simultaneous events:
  - redirect+stall in RUN -> redirect wins.
  - start+redirect in IDLE -> pc<=redirect_addr and state<=RUN in the same edge.
- start is a level; holding it high in RUN has no effect.

Test Plan:
- Reset then start, imem[0..2]=16'h1234,16'h5678,16'h9ABC, stall=0 -> instr_valid rises one cycle after RUN entry; instr sequence 1234,5678,9ABC; instr_pc 0,1,2; imem_addr 0,1,2,3.
- Stall held 3 cycles while instr=5678, instr_pc=1 -> instr, instr_pc, imem_addr=2 and instr_valid=1 all unchanged for 3 cycles. Fetch resumes with 9ABC.
- redirect=1, redirect_addr=5'd20, with stall=1 asserted in the same cycle -> next cycle instr_valid=0, instr=0, imem_addr=20. The following cycle delivers imem[20] with instr_pc=20.
- PC at 31, imem[31]=16'h0001, imem[0]=16'h0002 -> instr 0001 (instr_pc=31), then 0002 (instr_pc=0); imem_addr wraps 31->0.
- imem[4]=16'hFFFF -> instr=FFFF valid with instr_pc=4, halted=1, imem_addr stays 4.
  - Next cycle with stall=0: instr_valid=0.
  - Then redirect to 5'd8: RUN, halted=0, imem[8] delivered.
- Synchronous reset asserted mid-RUN at pc=9 with instr_valid=1 -> after that edge pc=0, instr=0, instr_valid=0, halted=0, state IDLE. start is then required to refetch from 0.
